// File: rtl/leitor_display.sv
// Readback monitor for a multiplexed active-low 7-segment bus: filters each
// digit dwell for stability and reconstructs the BCD code shown on each digit.
module leitor_display #(
    parameter int NDIG    = 4,
    parameter int ESTAVEL = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [6:0]          segmentos,
    input  logic [NDIG-1:0]     anodos,
    output logic [4*NDIG-1:0]   digitos,
    output logic [NDIG-1:0]     validos,
    output logic                atualizado,
    output logic                erro,
    output logic                conflito
);

    // state      | meaning
    // OCIOSO     | bus blank or several anodes low, nothing being tracked
    // CONTANDO   | single-anode pair seen, counting identical samples
    // CONFIRMADO | current pair already committed, waiting for a change
    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        CONTANDO   = 2'd1,
        CONFIRMADO = 2'd2
    } estado_t;

    localparam int        IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [7:0] EST8 = 8'(ESTAVEL);

    estado_t             estado_q, estado_d;
    logic [7:0]          cont_q, cont_d;
    logic [NDIG-1:0]     anod_q;
    logic [6:0]          seg_q;
    logic [NDIG-1:0]     ref_anod_q, ref_anod_d;
    logic [6:0]          ref_seg_q, ref_seg_d;
    logic                mult_ant_q, mult_ant_d;
    logic [4*NDIG-1:0]   digitos_q, digitos_d;
    logic [NDIG-1:0]     validos_q, validos_d;
    logic                atu_q, atu_d;
    logic                erro_q, erro_d;
    logic                confl_q, confl_d;

    logic [3:0]          n_baixos;
    logic [IDXW-1:0]     idx;
    logic                unico, multiplo, igual;
    logic                inicia, commit;
    logic [4:0]          dec;

    // Returns {valid, code}; an all-dark digit decodes as a valid blank (F).
    function automatic logic [4:0] decodifica(input logic [6:0] seg_n);
        logic [6:0] s;
        logic [4:0] r;
        s = ~seg_n;
        case (s)
            7'b1111110: r = {1'b1, 4'h0};
            7'b0110000: r = {1'b1, 4'h1};
            7'b1101101: r = {1'b1, 4'h2};
            7'b1111001: r = {1'b1, 4'h3};
            7'b0110011: r = {1'b1, 4'h4};
            7'b1011011: r = {1'b1, 4'h5};
            7'b1011111: r = {1'b1, 4'h6};
            7'b1110000: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1110011: r = {1'b1, 4'h9};
            7'b0000000: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    always_comb begin
        n_baixos = '0;
        idx      = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!anod_q[i]) begin
                n_baixos = n_baixos + 4'd1;
                idx      = IDXW'(i);
            end
        end
    end

    assign unico    = (n_baixos == 4'd1);
    assign multiplo = (n_baixos > 4'd1);
    assign igual    = (anod_q == ref_anod_q) && (seg_q == ref_seg_q);
    assign dec      = decodifica(seg_q);

    always_comb begin
        estado_d   = estado_q;
        cont_d     = cont_q;
        ref_anod_d = ref_anod_q;
        ref_seg_d  = ref_seg_q;
        digitos_d  = digitos_q;
        validos_d  = validos_q;
        atu_d      = 1'b0;
        erro_d     = 1'b0;
        confl_d    = multiplo && !mult_ant_q;
        mult_ant_d = multiplo;
        inicia     = 1'b0;
        commit     = 1'b0;

        case (estado_q)
            OCIOSO: begin
                cont_d = '0;
                if (unico) inicia = 1'b1;
            end
            CONTANDO: begin
                if (!unico) begin
                    estado_d = OCIOSO;
                    cont_d   = '0;
                end else if (igual) begin
                    cont_d = cont_q + 8'd1;
                    if (cont_d >= EST8) begin
                        cont_d   = EST8;
                        estado_d = CONFIRMADO;
                        commit   = 1'b1;
                    end
                end else begin
                    inicia = 1'b1;
                end
            end
            CONFIRMADO: begin
                if (!unico) begin
                    estado_d = OCIOSO;
                    cont_d   = '0;
                end else if (!igual) begin
                    inicia = 1'b1;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cont_d   = '0;
            end
        endcase

        // A new run counts its first sample; with ESTAVEL=1 that alone commits.
        if (inicia) begin
            ref_anod_d = anod_q;
            ref_seg_d  = seg_q;
            cont_d     = 8'd1;
            if (EST8 <= 8'd1) begin
                estado_d = CONFIRMADO;
                commit   = 1'b1;
            end else begin
                estado_d = CONTANDO;
            end
        end

        if (commit) begin
            atu_d = 1'b1;
            if (dec[4]) begin
                digitos_d[4*idx +: 4] = dec[3:0];
                validos_d[idx]        = 1'b1;
            end else begin
                validos_d[idx] = 1'b0;
                erro_d         = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            cont_q     <= '0;
            anod_q     <= '1;
            seg_q      <= '1;
            ref_anod_q <= '1;
            ref_seg_q  <= '1;
            mult_ant_q <= 1'b0;
            digitos_q  <= '1;
            validos_q  <= '0;
            atu_q      <= 1'b0;
            erro_q     <= 1'b0;
            confl_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cont_q     <= cont_d;
            anod_q     <= anodos;
            seg_q      <= segmentos;
            ref_anod_q <= ref_anod_d;
            ref_seg_q  <= ref_seg_d;
            mult_ant_q <= mult_ant_d;
            digitos_q  <= digitos_d;
            validos_q  <= validos_d;
            atu_q      <= atu_d;
            erro_q     <= erro_d;
            confl_q    <= confl_d;
        end
    end

    assign digitos    = digitos_q;
    assign validos    = validos_q;
    assign atualizado = atu_q;
    assign erro       = erro_q;
    assign conflito   = confl_q;

endmodule

// File: tb/tb_leitor_display.sv
// Bench for leitor_display: two instances (ESTAVEL=3 and ESTAVEL=1) share one
// stimulus stream and are compared every cycle against a run-length model.
module tb_leitor_display;

    logic        clock;
    logic        reset;
    logic [6:0]  segmentos;
    logic [3:0]  anodos;

    logic [15:0] dig_a, dig_b;
    logic [3:0]  val_a, val_b;
    logic        atu_a, atu_b, err_a, err_b, con_a, con_b;

    leitor_display #(.NDIG(4), .ESTAVEL(3)) dut_a (
        .clock(clock), .reset(reset), .segmentos(segmentos), .anodos(anodos),
        .digitos(dig_a), .validos(val_a), .atualizado(atu_a), .erro(err_a),
        .conflito(con_a)
    );

    leitor_display #(.NDIG(4), .ESTAVEL(1)) dut_b (
        .clock(clock), .reset(reset), .segmentos(segmentos), .anodos(anodos),
        .digitos(dig_b), .validos(val_b), .atualizado(atu_b), .erro(err_b),
        .conflito(con_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // Active-high abcdefg patterns of digits 0..9.
    logic [6:0] enc [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1110011};

    int          est [2] = '{3, 1};
    int          m_run [2];
    logic [15:0] m_dig [2];
    logic [3:0]  m_val [2];
    logic        m_atu [2];
    logic        m_err [2];
    logic        m_con [2];
    logic [10:0] m_smp, m_last;
    logic        m_multprev;
    int          c_atu [2];
    int          c_err [2];
    int          c_con [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] m_decode(input logic [6:0] sg);
        logic [6:0] on;
        on = ~sg;
        if (on == 7'd0) return {1'b1, 4'hF};
        for (int j = 0; j < 10; j++)
            if (enc[j] == on) return {1'b1, 4'(j)};
        return 5'd0;
    endfunction

    // Commit happens on the edge where a single-anode pair has been seen in
    // exactly est consecutive samples.
    task automatic model_step();
        int       nlow, d;
        logic     single, mult;
        logic [4:0] dc;
        if (reset) begin
            m_smp = '1;
            m_last = '1;
            m_multprev = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_run[k] = 0; m_dig[k] = 16'hFFFF; m_val[k] = 4'h0;
                m_atu[k] = 1'b0; m_err[k] = 1'b0; m_con[k] = 1'b0;
            end
        end else begin
            nlow = $countones(~m_smp[10:7]);
            single = (nlow == 1);
            mult = (nlow > 1);
            d = 0;
            for (int i = 0; i < 4; i++) if (!m_smp[7+i]) d = i;
            dc = m_decode(m_smp[6:0]);
            for (int k = 0; k < 2; k++) begin
                if (!single) m_run[k] = 0;
                else if (m_run[k] > 0 && m_smp == m_last) m_run[k] = (m_run[k] < 1000) ? m_run[k] + 1 : m_run[k];
                else m_run[k] = 1;
                m_atu[k] = 1'b0;
                m_err[k] = 1'b0;
                m_con[k] = mult && !m_multprev;
                if (m_run[k] == est[k]) begin
                    m_atu[k] = 1'b1;
                    if (dc[4]) begin
                        m_dig[k][4*d +: 4] = dc[3:0];
                        m_val[k][d] = 1'b1;
                    end else begin
                        m_val[k][d] = 1'b0;
                        m_err[k] = 1'b1;
                    end
                end
            end
            m_multprev = mult;
            m_last = m_smp;
            m_smp = {anodos, segmentos};
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        chk("a.digitos", 64'(dig_a), 64'(m_dig[0]));
        chk("a.validos", 64'(val_a), 64'(m_val[0]));
        chk("a.atualizado", 64'(atu_a), 64'(m_atu[0]));
        chk("a.erro", 64'(err_a), 64'(m_err[0]));
        chk("a.conflito", 64'(con_a), 64'(m_con[0]));
        chk("b.digitos", 64'(dig_b), 64'(m_dig[1]));
        chk("b.validos", 64'(val_b), 64'(m_val[1]));
        chk("b.atualizado", 64'(atu_b), 64'(m_atu[1]));
        chk("b.erro", 64'(err_b), 64'(m_err[1]));
        chk("b.conflito", 64'(con_b), 64'(m_con[1]));
        if (atu_a) c_atu[0]++;
        if (atu_b) c_atu[1]++;
        if (err_a) c_err[0]++;
        if (err_b) c_err[1]++;
        if (con_a) c_con[0]++;
        if (con_b) c_con[1]++;
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            c_atu[k] = 0; c_err[k] = 0; c_con[k] = 0;
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
        anodos = an;
        segmentos = sg;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] sg;
        int         r;

        reset = 1'b1;
        anodos = 4'hF;
        segmentos = 7'h7F;
        clr();
        tick();
        tick();
        chk("rst.digitos", 64'(dig_a), 64'hFFFF);
        chk("rst.validos", 64'(val_a), 64'h0);
        reset = 1'b0;

        // 1: "3" on digit 0 for the minimum three sampled edges
        clr();
        hold(4'b1110, 7'b0000110, 3);
        hold(4'b1111, 7'h7F, 4);
        chk("t1.dig0", 64'(dig_a[3:0]), 64'h3);
        chk("t1.validos", 64'(val_a), 64'b0001);
        chk("t1.n_atu", 64'(c_atu[0]), 64'd1);
        chk("t1.n_erro", 64'(c_err[0]), 64'd0);

        // 2: short "3" glitch followed by a stable "2" on digit 1
        clr();
        hold(4'b1101, 7'b0000110, 2);
        hold(4'b1101, 7'b0010010, 3);
        hold(4'b1111, 7'h7F, 4);
        chk("t2.dig1", 64'(dig_a[7:4]), 64'h2);
        chk("t2.n_atu", 64'(c_atu[0]), 64'd1);

        // 3: unrecognised pattern on digit 2 keeps the stored 5
        hold(4'b1011, 7'b0100100, 3);
        hold(4'b1111, 7'h7F, 4);
        clr();
        hold(4'b1011, 7'b0111111, 3);
        hold(4'b1111, 7'h7F, 4);
        chk("t3.dig2", 64'(dig_a[11:8]), 64'h5);
        chk("t3.validos", 64'(val_a), 64'b0011);
        chk("t3.n_erro", 64'(c_err[0]), 64'd1);
        chk("t3.n_atu", 64'(c_atu[0]), 64'd1);

        // 4: two anodes low for ten edges, then blank bus
        clr();
        hold(4'b1100, 7'b0000000, 10);
        chk("t4.n_confl", 64'(c_con[0]), 64'd1);
        chk("t4.n_atu", 64'(c_atu[0]), 64'd0);
        clr();
        hold(4'b1111, 7'h7F, 5);
        chk("t4.blank_pulses", 64'(c_con[0] + c_atu[0] + c_err[0]), 64'd0);
        chk("t4.digitos", 64'(dig_a), 64'hF523);

        // 5: reset in the middle of a count
        hold(4'b0111, 7'b0001111, 2);
        reset = 1'b1;
        tick();
        chk("t5.rst_digitos", 64'(dig_a), 64'hFFFF);
        chk("t5.rst_validos", 64'(val_a), 64'h0);
        reset = 1'b0;
        hold(4'b0111, 7'b0001111, 3);
        chk("t5.no_early", 64'(val_a), 64'h0);
        tick();
        chk("t5.dig3", 64'(dig_a[15:12]), 64'h7);
        chk("t5.validos", 64'(val_a), 64'b1000);
        hold(4'b1111, 7'h7F, 3);

        // 6: scan 1,2,3,4 on digits 0..3, two passes
        clr();
        for (int rep = 0; rep < 2; rep++)
            for (int d = 0; d < 4; d++) begin
                an = ~(4'b0001 << d);
                sg = ~enc[d+1];
                hold(an, sg, 5);
            end
        hold(4'b1111, 7'h7F, 4);
        chk("t6.digitos", 64'(dig_a), 64'h4321);
        chk("t6.validos", 64'(val_a), 64'hF);
        chk("t6.n_atu", 64'(c_atu[0]), 64'd8);
        chk("t6.e1.digitos", 64'(dig_b), 64'h4321);
        chk("t6.e1.n_atu", 64'(c_atu[1]), 64'd8);

        // Random traffic against the model
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) an = ~(4'b0001 << $urandom_range(0, 3));
            else if (r < 85) an = 4'hF;
            else an = 4'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 60) sg = ~enc[$urandom_range(0, 9)];
            else if (r < 70) sg = 7'h7F;
            else sg = 7'($urandom);
            reset = ($urandom_range(0, 99) < 2);
            hold(an, sg, int'($urandom_range(1, 6)));
            reset = 1'b0;
        end
        hold(4'hF, 7'h7F, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
